// File: rtl/rand_range_sampler.sv
// Rejection sampler: turns a free-running 8-bit LFSR word into an unbiased value in [0, RANGE-1].
// Each draw takes at most MAX_TRIES samples; after that the last candidate is folded into range.
module rand_range_sampler #(
  parameter int RANGE     = 6,
  parameter int MAX_TRIES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rnd_in,
  input  logic        ack,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  value,
  output logic [3:0]  tries,
  output logic        fallback,
  output logic [15:0] draw_cnt
);

  localparam int         MASK_W   = (RANGE > 1) ? $clog2(RANGE) : 1;
  localparam logic [7:0] MASK8    = 8'((1 << MASK_W) - 1);
  localparam logic [8:0] RANGE9   = 9'(RANGE);
  localparam logic [7:0] RANGE8   = 8'(RANGE);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_HOLD} state_t;

  state_t      r_state, w_state_next;
  logic        r_busy, w_busy_next;
  logic        r_valid, w_valid_next;
  logic [7:0]  r_value, w_value_next;
  logic [3:0]  r_tries, w_tries_next;
  logic        r_fallback, w_fallback_next;
  logic [15:0] r_draw_cnt, w_draw_cnt_next;

  logic [7:0]  w_cand;
  logic [7:0]  w_fold;
  logic        w_accept;

  // MASK < 2*RANGE, so a rejected candidate minus RANGE is always in range.
  assign w_cand   = rnd_in & MASK8;
  assign w_fold   = w_cand - RANGE8;
  assign w_accept = ({1'b0, w_cand} < RANGE9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_value    <= 8'd0;
      r_tries    <= 4'd0;
      r_fallback <= 1'b0;
      r_draw_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_busy     <= w_busy_next;
      r_valid    <= w_valid_next;
      r_value    <= w_value_next;
      r_tries    <= w_tries_next;
      r_fallback <= w_fallback_next;
      r_draw_cnt <= w_draw_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_busy_next     = r_busy;
    w_valid_next    = r_valid;
    w_value_next    = r_value;
    w_tries_next    = r_tries;
    w_fallback_next = r_fallback;
    w_draw_cnt_next = r_draw_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_SAMPLE;
          w_busy_next     = 1'b1;
          w_tries_next    = 4'd0;
          w_fallback_next = 1'b0;
        end
      end
      S_SAMPLE: begin
        if (w_accept) begin
          w_value_next = w_cand;
          w_valid_next = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_tries_next = r_tries + 4'd1;
          if (r_tries == LAST_TRY) begin
            w_value_next    = w_fold;
            w_fallback_next = 1'b1;
            w_valid_next    = 1'b1;
            w_state_next    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A start arriving together with ack is deliberately dropped.
        if (ack) begin
          w_valid_next    = 1'b0;
          w_busy_next     = 1'b0;
          w_draw_cnt_next = r_draw_cnt + 16'd1;
          w_state_next    = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
        w_valid_next = 1'b0;
      end
    endcase
  end

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign value    = r_value;
  assign tries    = r_tries;
  assign fallback = r_fallback;
  assign draw_cnt = r_draw_cnt;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Bench for rand_range_sampler: four configurations share one stimulus stream and are each
// checked against an arithmetic rejection-sampling model.
module tb_rand_range_sampler;

  localparam int N = 4;
  localparam int RG [N] = '{6, 6, 8, 200};
  localparam int MT [N] = '{15, 4, 15, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rnd_in;
  logic        ack;
  logic        busy_w     [N];
  logic        valid_w    [N];
  logic [7:0]  value_w    [N];
  logic [3:0]  tries_w    [N];
  logic        fallback_w [N];
  logic [15:0] cnt_w      [N];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  smp [15];
  int          e_k [N];
  int          e_val [N];
  int          e_nt [N];
  bit          e_fb [N];
  int          e_cnt [N];
  int          prev_val [N];

  always #5 clk = ~clk;

  rand_range_sampler #(.RANGE(6), .MAX_TRIES(15)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in), .ack(ack),
    .busy(busy_w[0]), .valid(valid_w[0]), .value(value_w[0]), .tries(tries_w[0]),
    .fallback(fallback_w[0]), .draw_cnt(cnt_w[0]));
  rand_range_sampler #(.RANGE(6), .MAX_TRIES(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in), .ack(ack),
    .busy(busy_w[1]), .valid(valid_w[1]), .value(value_w[1]), .tries(tries_w[1]),
    .fallback(fallback_w[1]), .draw_cnt(cnt_w[1]));
  rand_range_sampler #(.RANGE(8), .MAX_TRIES(15)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in), .ack(ack),
    .busy(busy_w[2]), .valid(valid_w[2]), .value(value_w[2]), .tries(tries_w[2]),
    .fallback(fallback_w[2]), .draw_cnt(cnt_w[2]));
  rand_range_sampler #(.RANGE(200), .MAX_TRIES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in), .ack(ack),
    .busy(busy_w[3]), .valid(valid_w[3]), .value(value_w[3]), .tries(tries_w[3]),
    .fallback(fallback_w[3]), .draw_cnt(cnt_w[3]));

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // Reference: candidate = sample mod next power of two; accept below range, else count a
  // rejection and, on the last allowed sample, subtract range.
  function automatic void model_draw(input int rg, input int mt, input logic [7:0] s [15],
                                     output int k, output int val, output int nt, output bit fb);
    int span;
    int c;
    span = 1;
    while (span < rg) span = span * 2;
    nt = 0; fb = 1'b0; val = 0; k = mt;
    for (int j = 0; j < mt; j++) begin
      c = int'(s[j]) % span;
      if (c < rg) begin
        val = c; k = j + 1;
        return;
      end
      nt++;
      if (nt == mt) begin
        val = c - rg; fb = 1'b1; k = j + 1;
        return;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_draw(input bit ack_with_start, input int hold_cycles);
    int kmax;
    kmax = 0;
    for (int i = 0; i < N; i++) begin
      model_draw(RG[i], MT[i], smp, e_k[i], e_val[i], e_nt[i], e_fb[i]);
      if (e_k[i] > kmax) kmax = e_k[i];
    end
    start = 1'b1;
    rnd_in = 8'($urandom);
    tick();
    start = 1'b0;
    for (int j = 0; j <= kmax; j++) begin
      for (int i = 0; i < N; i++) begin
        chk("busy", i, 32'(busy_w[i]), 32'd1);
        chk("valid_latency", i, 32'(valid_w[i]), 32'(j >= e_k[i]));
        if (j == 0) begin
          chk("tries_cleared", i, 32'(tries_w[i]), 32'd0);
          chk("fallback_cleared", i, 32'(fallback_w[i]), 32'd0);
          chk("value_held", i, 32'(value_w[i]), 32'(prev_val[i]));
        end
      end
      if (j == kmax) break;
      rnd_in = smp[j];
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    for (int h = 0; h <= hold_cycles; h++) begin
      for (int i = 0; i < N; i++) begin
        chk("valid_hold", i, 32'(valid_w[i]), 32'd1);
        chk("value", i, 32'(value_w[i]), 32'(e_val[i]));
        chk("tries", i, 32'(tries_w[i]), 32'(e_nt[i]));
        chk("fallback", i, 32'(fallback_w[i]), 32'(e_fb[i]));
      end
      if (h == hold_cycles) break;
      rnd_in = 8'($urandom);
      tick();
    end
    ack = 1'b1;
    start = ack_with_start;
    tick();
    ack = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      e_cnt[i] = (e_cnt[i] + 1) & 16'hFFFF;
      prev_val[i] = e_val[i];
      chk("valid_after_ack", i, 32'(valid_w[i]), 32'd0);
      chk("busy_after_ack", i, 32'(busy_w[i]), 32'd0);
      chk("draw_cnt", i, 32'(cnt_w[i]), 32'(e_cnt[i]));
    end
    tick();
    for (int i = 0; i < N; i++) begin
      chk("no_queued_start", i, 32'(busy_w[i]), 32'd0);
      chk("value_kept_idle", i, 32'(value_w[i]), 32'(e_val[i]));
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < 15; j++) smp[j] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; rnd_in = 8'd0;
    for (int i = 0; i < N; i++) begin
      e_cnt[i] = 0; prev_val[i] = 0;
    end
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("rst_valid", i, 32'(valid_w[i]), 32'd0);
      chk("rst_value", i, 32'(value_w[i]), 32'd0);
      chk("rst_tries", i, 32'(tries_w[i]), 32'd0);
      chk("rst_cnt", i, 32'(cnt_w[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Immediate accept of candidate 3.
    fill_random();
    smp[0] = 8'h23;
    run_draw(1'b0, 0);
    chk("t1_value", 0, 32'(value_w[0]), 32'd3);
    chk("t1_tries", 0, 32'(tries_w[0]), 32'd0);

    // Two rejections then accept.
    fill_random();
    smp[0] = 8'h07; smp[1] = 8'h0E; smp[2] = 8'h02;
    run_draw(1'b0, 0);
    chk("t2_value", 0, 32'(value_w[0]), 32'd2);
    chk("t2_tries", 0, 32'(tries_w[0]), 32'd2);

    // Forced fallback with rnd_in stuck at FF.
    for (int j = 0; j < 15; j++) smp[j] = 8'hFF;
    run_draw(1'b0, 0);
    chk("t3_value", 1, 32'(value_w[1]), 32'd1);
    chk("t3_tries", 1, 32'(tries_w[1]), 32'd4);
    chk("t3_fallback", 1, 32'(fallback_w[1]), 32'd1);

    // Long hold while rnd_in moves, then ack together with start; accept of zero.
    fill_random();
    smp[0] = 8'h00;
    run_draw(1'b1, 10);

    // ack in IDLE must do nothing.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("idle_ack_cnt", i, 32'(cnt_w[i]), 32'(e_cnt[i]));
      chk("idle_ack_busy", i, 32'(busy_w[i]), 32'd0);
    end

    // Asynchronous reset in the middle of sampling.
    start = 1'b1;
    tick();
    start = 1'b0;
    rnd_in = 8'h07;
    tick();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("async_busy", i, 32'(busy_w[i]), 32'd0);
      chk("async_valid", i, 32'(valid_w[i]), 32'd0);
      chk("async_value", i, 32'(value_w[i]), 32'd0);
      chk("async_tries", i, 32'(tries_w[i]), 32'd0);
      chk("async_fallback", i, 32'(fallback_w[i]), 32'd0);
      chk("async_cnt", i, 32'(cnt_w[i]), 32'd0);
      e_cnt[i] = 0; prev_val[i] = 0;
    end
    tick();
    rst = 1'b0;
    tick();
    fill_random();
    run_draw(1'b0, 1);

    for (int d = 0; d < 30; d++) begin
      fill_random();
      run_draw(1'($urandom_range(0, 1)), $urandom_range(0, 3));
      chk("pow2_tries", 2, 32'(tries_w[2]), 32'd0);
      chk("pow2_fallback", 2, 32'(fallback_w[2]), 32'd0);
    end

    // Draw counter wrap.
    force u_dut0.r_draw_cnt = 16'hFFFF;
    #1;
    release u_dut0.r_draw_cnt;
    e_cnt[0] = 16'hFFFF;
    chk("cnt_preload", 0, 32'(cnt_w[0]), 32'hFFFF);
    tick();
    fill_random();
    run_draw(1'b0, 0);
    chk("cnt_wrap", 0, 32'(cnt_w[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
